debounce_bank: RTL
==================

// Module: debounce_bank
// PURPOSE
//  Parametrised multi-channel push-button conditioner for the front-panel inputs.
//  Each raw button is synchronised, sampled on a shared slow tick and debounced by
//  requiring DEPTH equal samples. Per channel it produces a clean level, one-clk
//  rise/fall pulses, and an optional auto-repeat press pulse for held up/down keys.
//  Sits between the board pins and the control FSM; replaces the fixed 9-input filter.
// PARAMETERS
//  N_CH         9       number of button channels
//  TICK_DIV     2001    sample period in clk cycles (>=2)
//  DEPTH        6       consecutive equal samples needed to change level (>=2)
//  REPEAT_DELAY 250     ticks from rise to first auto-repeat pulse (>=1)
//  REPEAT_RATE  25      ticks between subsequent auto-repeat pulses (>=1)
//  REPEAT_MASK  9'h003  bit i=1 enables auto-repeat on channel i
// PORTS
//  clk     in   1     system clock
//  reset   in   1     synchronous, active-high reset
//  btn_in  in   N_CH  raw asynchronous button inputs, active-high
//  level   out  N_CH  debounced level
//  rise    out  N_CH  1-clk pulse when level goes 0->1
//  fall    out  N_CH  1-clk pulse when level goes 1->0
//  press   out  N_CH  1-clk pulse: rise OR auto-repeat event
//  tick    out  1     1-clk sample strobe (shared, for debug/test)
// BEHAVIOUR
//  - Reset: prescaler=0, sync FFs, history, repeat counters, and all outputs = 0.
//    Reset wins over every other event; no fall pulse when reset clears level.
//  - Synchroniser: 2-FF per channel; sync = 2nd stage.
//  - Prescaler: cnt 0..TICK_DIV-1, wraps; tick=1 exactly when cnt==TICK_DIV-1.
//  - On tick: new_hist = {hist[DEPTH-2:0], sync}; hist <= new_hist.
//    If new_hist all-1 and level==0: level<=1, rise<=1 (same edge).
//    If new_hist all-0 and level==1: level<=0, fall<=1 (same edge).
//    Otherwise level holds. Non-tick cycles: hist and level hold.
//  - rise/fall/press are registered and high for exactly one clk cycle.
//  - Latency: a clean edge is reflected DEPTH ticks after first sampled
//    (+2 clk synchroniser); glitches spanning <DEPTH ticks are never seen.
//  - Auto-repeat (REPEAT_MASK[i]=1): on rise load rcnt=REPEAT_DELAY. On each tick
//    with level==1 and no level change: if rcnt==1, press pulse and reload
//    REPEAT_RATE; else rcnt--. On fall, rcnt<=0. rise and repeat never coincide;
//    press = rise | repeat. Unmasked channels: press == rise, rcnt unused.
//  - rcnt width = $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1); no wrap possible.
//  - Reset released with a button held: treated as new press after DEPTH ticks.
//  - Channels fully independent; simultaneous events on many channels allowed.
// STRUCTURE
//  - Shared package/include: default constants (N_CH, TICK_DIV, DEPTH, repeat
//    defaults) and channel index names (CH_UP=0, CH_DOWN=1, CH_LEFT=2, ...).
//  - Top: prescaler + generate loop of N_CH instances of sub-module
//    debounce_channel (sync, history, level, edges, repeat counter), with
//    REPEAT_EN=REPEAT_MASK[i] passed per instance.
// TESTING (bench params: TICK_DIV=4, DEPTH=3, REPEAT_DELAY=5, REPEAT_RATE=2)
//  1 Reset: all outputs 0 during/after reset with btn_in=all-1 held; tick every 4 clk.
//  2 Bounce: ch2 toggles every 6 clk for 200 clk -> level[2] stays 0, no pulses.
//  3 Clean press/release ch3 (unmasked): hold 1 -> level rises at 3rd tick sampling 1,
//    rise=press=1 for one clk; release -> fall after 3 ticks; press never repeats.
//  4 Auto-repeat ch0 held 100 clk: press at rise, again 20 clk later, then every 8 clk;
//    release stops pulses, fall once.
//  5 Reset mid-hold on ch1 (level=1): level 0 next clk, no fall; after reset,
//    rise again 3 ticks later.
//  6 Simultaneous press ch0, ch4, ch8 same cycle -> rise pulses on same clk, others 0.

Source files
------------

// File: rtl/debounce_bank_pkg.sv
// -----------------------------------------------------------------------------
// debounce_bank_pkg
//   Shared constants for the front-panel button conditioner: default bank
//   geometry, timing defaults, the channel index names used by the control FSM,
//   and a helper that sizes the auto-repeat counter.
// -----------------------------------------------------------------------------
package debounce_bank_pkg;

    localparam int N_CH_DEF         = 9;
    localparam int TICK_DIV_DEF     = 2001;
    localparam int DEPTH_DEF        = 6;
    localparam int REPEAT_DELAY_DEF = 250;
    localparam int REPEAT_RATE_DEF  = 25;
    localparam logic [N_CH_DEF-1:0] REPEAT_MASK_DEF = 9'h003;

    // Front-panel channel assignment.
    localparam int CH_UP    = 0;
    localparam int CH_DOWN  = 1;
    localparam int CH_LEFT  = 2;
    localparam int CH_RIGHT = 3;
    localparam int CH_OK    = 4;
    localparam int CH_BACK  = 5;
    localparam int CH_MENU  = 6;
    localparam int CH_AUX0  = 7;
    localparam int CH_AUX1  = 8;

    // Width that holds the larger of the two repeat reloads without wrapping.
    function automatic int rcnt_width(input int delay, input int rate);
        int mx;
        mx = (delay > rate) ? delay : rate;
        return $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/debounce_bank_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One button channel: 2-FF synchroniser, DEPTH-deep sample history advanced
//   on the shared tick, debounced level with registered rise/fall pulses, and
//   an optional auto-repeat down-counter that adds extra press pulses while the
//   key is held.
// Ports
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   tick_i   in   shared sample strobe (one clk wide)
//   btn_i    in   raw asynchronous button, active-high
//   level_o  out  debounced level
//   rise_o   out  one-clk pulse on level 0->1
//   fall_o   out  one-clk pulse on level 1->0
//   press_o  out  one-clk pulse on rise or auto-repeat event
// -----------------------------------------------------------------------------
module debounce_channel
    import debounce_bank_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEF,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE  = REPEAT_RATE_DEF,
    parameter bit REPEAT_EN    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic press_o
);

    localparam int RW = rcnt_width(REPEAT_DELAY, REPEAT_RATE);
    localparam logic [RW-1:0] R_DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_RATE  = RW'(REPEAT_RATE);
    localparam logic [RW-1:0] R_ONE   = RW'(1);

    logic             sync1_q, sync2_q;
    logic [DEPTH-1:0] hist_q, hist_d, new_hist;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             press_q, press_d;
    logic [RW-1:0]    rcnt_q, rcnt_d;
    logic             hold_en;
    logic             rep_fire;

    always_comb begin
        new_hist = {hist_q[DEPTH-2:0], sync2_q};
        rise_d   = tick_i & (&new_hist) & ~level_q;
        fall_d   = tick_i & ~(|new_hist) & level_q;
        // Level is high and stays high on this tick: the only ticks that may
        // advance the repeat counter.
        hold_en  = tick_i & level_q & ~fall_d;
        rep_fire = REPEAT_EN & hold_en & (rcnt_q == R_ONE);
        press_d  = rise_d | rep_fire;

        hist_d   = tick_i ? new_hist : hist_q;
        level_d  = level_q;
        if (rise_d) begin
            level_d = 1'b1;
        end else if (fall_d) begin
            level_d = 1'b0;
        end

        rcnt_d = rcnt_q;
        if (REPEAT_EN) begin
            if (rise_d) begin
                rcnt_d = R_DELAY;
            end else if (fall_d) begin
                rcnt_d = '0;
            end else if (rep_fire) begin
                rcnt_d = R_RATE;
            end else if (hold_en && (rcnt_q != '0)) begin
                rcnt_d = rcnt_q - R_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            press_q <= 1'b0;
            rcnt_q  <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            hist_q  <= hist_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            press_q <= press_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign press_o = press_q;

endmodule

// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
//   Multi-channel push-button conditioner for the front panel. A shared
//   prescaler produces the slow sample tick; each channel is debounced by its
//   own debounce_channel instance, with auto-repeat enabled per REPEAT_MASK.
// Ports
//   clk     in   system clock
//   reset   in   synchronous, active-high reset
//   btn_in  in   [N_CH] raw asynchronous buttons, active-high
//   level   out  [N_CH] debounced level
//   rise    out  [N_CH] one-clk pulse on level 0->1
//   fall    out  [N_CH] one-clk pulse on level 1->0
//   press   out  [N_CH] one-clk pulse on rise or auto-repeat
//   tick    out  shared one-clk sample strobe
// -----------------------------------------------------------------------------
module debounce_bank
    import debounce_bank_pkg::*;
#(
    parameter int N_CH         = N_CH_DEF,
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE  = REPEAT_RATE_DEF,
    parameter logic [N_CH-1:0] REPEAT_MASK = N_CH'(REPEAT_MASK_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] press,
    output logic            tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decoded from the counter so the strobe lines up with the wrap cycle.
    assign tick = (cnt_q == CNT_LAST);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DEPTH        (DEPTH),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .REPEAT_EN    (REPEAT_MASK[i])
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .tick_i  (tick),
            .btn_i   (btn_in[i]),
            .level_o (level[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i]),
            .press_o (press[i])
        );
    end

endmodule
